line_memory_responder: RTL and testbench

- Memory-side responder for the data cache's line-fill and write-back traffic; it is the RAM end of the cache↔memory interface.
- Accepts one 128-bit line request at a time over a valid/ready handshake.
- Models a fixed access latency, then returns a response that is held until the cache accepts it.
- Replaces the zero-latency data memory path, so the cache controller must now tolerate multi-cycle misses.

---
 rtl/line_memory_responder_if.sv | 16 +
 rtl/line_memory_responder.sv | 78 +++++++
 tb/tb_line_memory_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/line_memory_responder_if.sv
// line_memory_responder_if: cache-to-memory line request/response channel
interface line_memory_responder_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_rdata;
  logic         resp_err;
  modport master(output req_valid, req_write, req_addr, req_wdata, resp_ready,
                 input req_ready, resp_valid, resp_rdata, resp_err);
  modport slave(input req_valid, req_write, req_addr, req_wdata, resp_ready,
                output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/line_memory_responder.sv
// line_memory_responder: fixed-latency line RAM answering one cache fill/write-back at a time
module line_memory_responder #(
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  line_memory_responder_if.slave bus,
  output logic                  busy
);
  localparam int LW = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           write_q, write_d;
  logic [27:0]    idx_q, idx_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [127:0]   rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [127:0]   mem_q [DEPTH_LINES];
  logic           hit;
  logic           we;
  // full 28-bit compare so upper address bits never alias into the array
  assign hit = idx_q < 28'(DEPTH_LINES);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    we      = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY - 1);
        write_d = bus.req_write;
        idx_d   = bus.req_addr[31:4];
        wdata_d = bus.req_wdata;
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d = RESP;
        we      = write_q & hit;
        rdata_d = !hit ? '0 : write_q ? wdata_q : mem_q[idx_q[LW-1:0]];
        err_d   = !hit;
      end else cnt_d = cnt_q - 4'd1;
      RESP: state_d = bus.resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_LINES; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (we) mem_q[idx_q[LW-1:0]] <= wdata_q;
    end
  end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_line_memory_responder.sv
// tb_line_memory_responder: random + directed checks of three responders (LATENCY 4, 1, 15) against a line-array model
module tb_line_memory_responder;
  logic clk;
  logic rst_n;
  logic         rv [3];
  logic         rw [3];
  logic [31:0]  ra [3];
  logic [127:0] wd [3];
  logic         rr [3];
  wire          q_rdy [3];
  wire          q_vld [3];
  wire          q_err [3];
  wire  [127:0] q_rd  [3];
  wire          q_busy [3];
  int checks = 0;
  int errors = 0;
  logic [127:0] mdl [3][64];
  localparam logic [127:0] PAT = 128'h0123456789ABCDEF_FEDCBA9876543210;
  for (genvar g = 0; g < 3; g++) begin : gd
    line_memory_responder_if b();
    assign b.req_valid  = rv[g];
    assign b.req_write  = rw[g];
    assign b.req_addr   = ra[g];
    assign b.req_wdata  = wd[g];
    assign b.resp_ready = rr[g];
    assign q_rdy[g] = b.req_ready;
    assign q_vld[g] = b.resp_valid;
    assign q_err[g] = b.resp_err;
    assign q_rd[g]  = b.resp_rdata;
    line_memory_responder #(.DEPTH_LINES(64), .LATENCY(g == 0 ? 4 : g == 1 ? 1 : 15)) dut (
      .clk(clk), .reset(rst_n), .bus(b.slave), .busy(q_busy[g]));
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int lat(int k);
    return k == 0 ? 4 : k == 1 ? 1 : 15;
  endfunction
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++) mdl[k][i] = '0;
  endtask
  task automatic chk_reset_state(int k);
    chk("rst_req_ready", q_rdy[k], 1);
    chk("rst_resp_valid", q_vld[k], 0);
    chk("rst_resp_err", q_err[k], 0);
    chk("rst_resp_rdata", q_rd[k], 0);
    chk("rst_busy", q_busy[k], 0);
  endtask
  task automatic txn(int k, bit w, logic [31:0] a, logic [127:0] d, int hold);
    logic [27:0]  idx;
    bit           inr;
    logic [127:0] exp_d;
    int           n;
    idx   = a[31:4];
    inr   = idx < 28'd64;
    exp_d = !inr ? '0 : w ? d : mdl[k][idx[5:0]];
    chk("req_ready_idle", q_rdy[k], 1);
    rv[k] = 1'b1; rw[k] = w; ra[k] = a; wd[k] = d;
    @(posedge clk); #1;
    rv[k] = 1'b0; rw[k] = 1'($urandom); ra[k] = $urandom;
    wd[k] = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!q_vld[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat(k));
    if (w && inr) mdl[k][idx[5:0]] = d;
    chk("rdata", q_rd[k], exp_d);
    chk("err", q_err[k], !inr);
    chk("busy_resp", q_busy[k], 1);
    for (int h = 0; h < hold; h++) begin
      rr[k] = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", q_vld[k], 1);
      chk("hold_req_ready", q_rdy[k], 0);
      chk("hold_rdata", q_rd[k], exp_d);
      chk("hold_err", q_err[k], !inr);
    end
    rr[k] = 1'b1;
    @(posedge clk); #1;
    rr[k] = 1'b0;
    chk("back_to_idle", {q_vld[k], q_rdy[k], q_busy[k]}, 3'b010);
  endtask
  task automatic b2b(int k);
    int acc[$];
    rv[k] = 1'b1; rw[k] = 1'b0; ra[k] = 32'h0; rr[k] = 1'b1;
    for (int c = 0; c < 4 * (lat(k) + 2); c++) begin
      if (q_rdy[k]) acc.push_back(c);
      @(posedge clk); #1;
    end
    rv[k] = 1'b0;
    repeat (lat(k) + 3) @(posedge clk);
    #1;
    rr[k] = 1'b0;
    chk("b2b_count_ok", acc.size() >= 3, 1);
    if (acc.size() >= 3) begin
      chk("b2b_gap0", acc[1] - acc[0], lat(k) + 2);
      chk("b2b_gap1", acc[2] - acc[1], lat(k) + 2);
    end
    chk("b2b_idle", q_rdy[k], 1);
  endtask
  initial begin
    logic [27:0]  idx;
    logic [127:0] d;
    int           r;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rv[k] = 0; rw[k] = 0; ra[k] = 0; wd[k] = 0; rr[k] = 0;
    end
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_reset_state(k);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk_reset_state(k);
    txn(0, 0, 32'h20, '0, 0);
    txn(0, 1, 32'h30, PAT, 0);
    txn(0, 0, 32'h3C, '0, 0);
    txn(0, 0, 32'h34, '0, 6);
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      idx = r == 0 ? 28'(64 + $urandom_range(0, 100)) :
            r == 1 ? {1'b1, 27'($urandom)} : 28'($urandom_range(0, 63));
      d = {$urandom, $urandom, $urandom, $urandom};
      txn(0, 1'($urandom), {idx, 4'($urandom)}, d, $urandom_range(0, 3));
    end
    txn(0, 0, 32'h400, '0, 0);
    txn(0, 1, 32'h400, ~PAT, 1);
    for (int i = 0; i < 64; i++) txn(0, 0, {22'd0, 6'(i), 4'($urandom)}, '0, 0);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h10; wd[0] = ~PAT;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_busy", q_busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk_reset_state(0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_state(0);
    txn(0, 0, 32'h10, '0, 0);
    for (int k = 1; k < 3; k++) begin
      txn(k, 1, 32'h50, PAT ^ 128'(k), 0);
      txn(k, 0, 32'h58, '0, 2);
      txn(k, 0, 32'h1000, '0, 0);
      b2b(k);
    end
    b2b(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
